timer_irq_ctrl: RTL and testbench
=================================

TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

Interface
REQ-001 Parameter: APB_ADDR_WIDTH, 12, APB address width.
REQ-002 Port: HCLK  input  1  single clock; all state on rising edge.
REQ-003 Port: HRESETn  input  1  reset, asynchronous, active-low.
REQ-004 Port: PADDR  input  APB_ADDR_WIDTH  APB address; word index PADDR[3:2].
REQ-005 Port: PWDATA  input  32  APB write data.
REQ-006 Port: PWRITE  input  1  APB write strobe.
REQ-007 Port: PSEL  input  1  APB select.
REQ-008 Port: PENABLE  input  1  APB enable.
REQ-009 Port: PRDATA  output  32  APB read data; 0 when not in an access phase read.
REQ-010 Port: PREADY  output  1  constant 1.
REQ-011 Port: PSLVERR  output  1  constant 0.
REQ-012 Port: timer_irq_i  input  2  timer event pulses; bit0 overflow, bit1 compare match.
REQ-013 Port: irq_req_o  output  1  interrupt request to core.
REQ-014 Port: irq_id_o  output  1  source ID of current request.
REQ-015 Port: irq_ack_i  input  1  core acknowledge, one-cycle pulse.

Function
REQ-016 Register map (PADDR[3:2]) SHALL be: 0 PENDING (RO bits[1:0], write-1-to-clear); 1 MASK (RW bits[1:0]); 2 MISS (RO {16'b0, cnt1[7:0], cnt0[7:0]}, any write clears both); 3 STATUS (RO bit0 = busy, bit1 = irq_id_o); unused bits read 0.
REQ-017 APB write SHALL take effect on the edge ending the cycle with PSEL & PENABLE & PWRITE; read data SHALL be combinational from current registers.
REQ-018 timer_irq_i[k] high in cycle N SHALL set PENDING[k] from cycle N+1.
REQ-019 Set and W1C of the same PENDING bit in one cycle: set SHALL win.
REQ-020 timer_irq_i[k] high while PENDING[k] already 1 SHALL increment cnt k, saturating at 255.
REQ-021 FSM states SHALL be IDLE and REQ; busy = (state == REQ).
REQ-022 IDLE -> REQ when (PENDING & MASK) != 0; ID latched as 1 if bit1 qualifies, else 0 (compare has priority).
REQ-023 irq_req_o SHALL be 1 exactly in REQ; irq_id_o SHALL hold the latched ID, stable in REQ.
REQ-024 Latency: event in cycle N with mask set and FSM idle -> irq_req_o high from cycle N+2.
REQ-025 REQ -> IDLE on irq_ack_i; PENDING[ID] cleared on that edge unless a new event on that source arrives in the same cycle (then stays 1).
REQ-026 irq_ack_i in IDLE SHALL be ignored.
REQ-027 MASK clear or W1C of PENDING[ID] while in REQ SHALL NOT withdraw the request; it remains until ack.
REQ-028 After REQ -> IDLE, irq_req_o SHALL be low for at least one cycle before re-asserting.

Reset
REQ-029 HRESETn low SHALL immediately force FSM to IDLE, irq_req_o = 0, irq_id_o = 0, PENDING = 0, MASK = 0, cnt0 = cnt1 = 0, irrespective of clock.
REQ-030 Reset asserted mid-request SHALL drop irq_req_o without ack; events during reset SHALL be lost.

Configuration
REQ-031 Macro TIMER_IRQ_MISS_CNT_EN defined: miss counters per REQ-020 present, MISS register per REQ-016.
REQ-032 Macro TIMER_IRQ_MISS_CNT_EN undefined: no counter flops, MISS reads 0, writes to it ignored; all other behaviour unchanged.

Verification
REQ-033 MASK=2'b11, pulse timer_irq_i=2'b01 at cycle N -> PENDING=1 at N+1, irq_req_o=1, irq_id_o=0 at N+2; ack -> PENDING=0, irq_req_o=0 next cycle.
REQ-034 MASK=2'b11, pulse 2'b11 same cycle -> first request ID=1; after ack, second request ID=0 after exactly one low cycle.
REQ-035 MASK=0, pulse bit0 three times -> PENDING=2'b01, no request, MISS=0x0002 (with macro) / 0x0000 (without); write MISS -> reads 0.
REQ-036 300 pulses on bit1 with PENDING[1] held -> MISS[15:8]=255 saturated.
REQ-037 In REQ: clear MASK and W1C PENDING[ID] -> irq_req_o stays 1 until irq_ack_i; ack in IDLE -> no state change.
REQ-038 Assert HRESETn=0 mid-REQ between clock edges -> irq_req_o=0 immediately, all registers read 0 after release.

Source files
------------

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: APB-programmable interrupt controller for two timer event sources.
//
// Optional feature macro: TIMER_IRQ_MISS_CNT_EN
//   When it is defined, each source gets an 8-bit saturating miss counter. The counter
//   counts events that arrive while that source's PENDING bit is already set.
//   When it is undefined, there are no counter flops. MISS then reads 0 and writes to it
//   are ignored.
//
// Ports:
//   HCLK         in   clock; all state changes on its rising edge
//   HRESETn      in   asynchronous active-low reset
//   PADDR        in   APB address; PADDR[3:2] selects the word
//   PWDATA       in   APB write data
//   PWRITE       in   APB write strobe
//   PSEL         in   APB select
//   PENABLE      in   APB enable
//   PRDATA       out  APB read data; 0 outside an access-phase read
//   PREADY       out  tied to 1
//   PSLVERR      out  tied to 0
//   timer_irq_i  in   event pulses: bit0 overflow, bit1 compare match
//   irq_req_o    out  interrupt request to the core
//   irq_id_o     out  source of the current request (1 = compare)
//   irq_ack_i    in   one-cycle acknowledge from the core
//
// Register map (word index PADDR[3:2]):
//   0 PENDING  RO [1:0], write 1 to clear
//   1 MASK     RW [1:0]
//   2 MISS     RO {16'b0, cnt1, cnt0}; any write clears both counters
//   3 STATUS   RO {irq_id_o, busy}
module timer_irq_ctrl #(
    parameter int unsigned APB_ADDR_WIDTH = 12
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [1:0]                timer_irq_i,
    output logic                      irq_req_o,
    output logic                      irq_id_o,
    input  logic                      irq_ack_i
);

    typedef enum logic {
        StIdle,
        StReq
    } state_e;

    state_e     r_state;
    logic       r_irq_id;
    logic [1:0] r_pending;
    logic [1:0] r_mask;

    logic       w_wr;
    logic       w_rd;
    logic [1:0] w_idx;
    logic [1:0] w_qual;
    logic       w_ack;
    logic [1:0] w_pending_nxt;
    logic [7:0] w_cnt0;
    logic [7:0] w_cnt1;

    assign w_idx = PADDR[3:2];
    assign w_wr  = PSEL & PENABLE & PWRITE;
    assign w_rd  = PSEL & PENABLE & ~PWRITE;

    assign w_qual = r_pending & r_mask;
    // An acknowledge only counts while a request is outstanding.
    assign w_ack  = (r_state == StReq) & irq_ack_i;

    assign PREADY    = 1'b1;
    assign PSLVERR   = 1'b0;
    assign irq_req_o = (r_state == StReq);
    assign irq_id_o  = r_irq_id;

    // Only PADDR[3:2] and PWDATA[1:0] are decoded.
    logic w_unused_bits;
    assign w_unused_bits = ^{PADDR[APB_ADDR_WIDTH-1:4], PADDR[1:0], PWDATA[31:2]};

    // Pending next state. A new event is ORed in last, so it beats both a
    // write-1-to-clear and the acknowledge clear in the same cycle.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_wr && (w_idx == 2'd0)) begin
            w_pending_nxt = w_pending_nxt & ~PWDATA[1:0];
        end
        if (w_ack) begin
            w_pending_nxt[r_irq_id] = 1'b0;
        end
        w_pending_nxt = w_pending_nxt | timer_irq_i;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_pending <= 2'b00;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_mask <= 2'b00;
        end else if (w_wr && (w_idx == 2'd1)) begin
            r_mask <= PWDATA[1:0];
        end
    end

`ifdef TIMER_IRQ_MISS_CNT_EN
    logic [7:0] r_cnt0;
    logic [7:0] r_cnt1;

    // A write to MISS takes precedence over a same-cycle increment.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cnt0 <= 8'h00;
            r_cnt1 <= 8'h00;
        end else if (w_wr && (w_idx == 2'd2)) begin
            r_cnt0 <= 8'h00;
            r_cnt1 <= 8'h00;
        end else begin
            if (timer_irq_i[0] && r_pending[0] && (r_cnt0 != 8'hFF)) begin
                r_cnt0 <= r_cnt0 + 8'd1;
            end
            if (timer_irq_i[1] && r_pending[1] && (r_cnt1 != 8'hFF)) begin
                r_cnt1 <= r_cnt1 + 8'd1;
            end
        end
    end

    assign w_cnt0 = r_cnt0;
    assign w_cnt1 = r_cnt1;
`else
    assign w_cnt0 = 8'h00;
    assign w_cnt1 = 8'h00;
`endif

    // Request FSM. The request comes straight from the state flop. Leaving StReq
    // always passes through StIdle, so there is at least one low cycle between requests.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= StIdle;
            r_irq_id <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (|w_qual) begin
                        r_state  <= StReq;
                        r_irq_id <= w_qual[1];  // compare match has priority
                    end
                end
                StReq: begin
                    if (irq_ack_i) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        PRDATA = 32'h0000_0000;
        if (w_rd) begin
            unique case (w_idx)
                2'd0: PRDATA = {30'b0, r_pending};
                2'd1: PRDATA = {30'b0, r_mask};
                2'd2: PRDATA = {16'b0, w_cnt1, w_cnt0};
                2'd3: PRDATA = {30'b0, r_irq_id, (r_state == StReq)};
                default: PRDATA = 32'h0000_0000;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
module tb_timer_irq_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [1:0]  timer_irq_i;
    logic        irq_req_o;
    logic        irq_id_o;
    logic        irq_ack_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [1:0] m_pend;
    logic [1:0] m_mask;
    int         m_cnt0;
    int         m_cnt1;
    bit         m_busy;
    bit         m_id;

    timer_irq_ctrl #(.APB_ADDR_WIDTH(12)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .timer_irq_i (timer_irq_i),
        .irq_req_o   (irq_req_o),
        .irq_id_o    (irq_id_o),
        .irq_ack_i   (irq_ack_i)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_pend = 2'b00;
        m_mask = 2'b00;
        m_cnt0 = 0;
        m_cnt1 = 0;
        m_busy = 0;
        m_id   = 0;
    endfunction

    function automatic logic [31:0] exp_reg(input logic [1:0] idx);
        logic [31:0] c0;
        logic [31:0] c1;
        c0 = m_cnt0;
        c1 = m_cnt1;
        case (idx)
            2'd0: return {30'b0, m_pend};
            2'd1: return {30'b0, m_mask};
`ifdef TIMER_IRQ_MISS_CNT_EN
            2'd2: return {16'b0, c1[7:0], c0[7:0]};
`else
            2'd2: return 32'h0;
`endif
            default: return {30'b0, m_id, m_busy};
        endcase
    endfunction

    // One clock: model consumes the inputs currently applied, then the edge happens.
    task automatic step();
        logic [1:0] np;
        logic [1:0] nm;
        bit         nb;
        bit         ni;
        bit         wr;
        logic [1:0] idx;
        wr  = PSEL && PENABLE && PWRITE;
        idx = PADDR[3:2];
        np  = m_pend;
        nm  = m_mask;
        nb  = m_busy;
        ni  = m_id;
        if (wr && idx == 2'd0) np = np & ~PWDATA[1:0];
        if (wr && idx == 2'd1) nm = PWDATA[1:0];
        if (wr && idx == 2'd2) begin
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            if (timer_irq_i[0] && m_pend[0]) m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
            if (timer_irq_i[1] && m_pend[1]) m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
        end
        if (m_busy) begin
            if (irq_ack_i) begin
                np[m_id] = 1'b0;
                nb = 0;
            end
        end else if ((m_pend & m_mask) != 2'b00) begin
            nb = 1;
            ni = (m_pend[1] && m_mask[1]);
        end
        np = np | timer_irq_i;
        @(posedge HCLK);
        m_pend = np;
        m_mask = nm;
        m_busy = nb;
        m_id   = ni;
        #1;
    endtask

    task automatic apb_write(input logic [1:0] idx, input logic [31:0] data);
        PADDR   = 12'($urandom);
        PADDR[3:2] = idx;
        PWDATA  = data;
        PWRITE  = 1'b1;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        step();
        PENABLE = 1'b1;
        step();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apb_read(input logic [1:0] idx, output logic [31:0] data);
        PADDR   = 12'($urandom);
        PADDR[3:2] = idx;
        PWRITE  = 1'b0;
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        #1;
        data    = PRDATA;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        HRESETn     = 1'b0;
        PADDR       = 12'h00C;
        PWDATA      = 32'h0;
        PWRITE      = 1'b0;
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        timer_irq_i = 2'b00;
        irq_ack_i   = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (irq_req_o !== 1'b0 || irq_id_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: req=%b id=%b, required 0 0", irq_req_o, irq_id_o);
        end
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        step();
        n_checks++;
        if (PRDATA !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_prdata_idle: got %h, required 0", PRDATA);
        end
        for (int i = 0; i < 4; i++) begin
            apb_read(2'(i), d);
            n_checks++;
            if (d !== 32'h0) begin
                n_errors++;
                $display("FAIL reset_reg%0d: got %h, required 0", i, d);
            end
        end
    endtask

    task automatic test_single();
        logic [31:0] d;
        apb_write(2'd1, 32'h3);
        // setup phase read must not drive data
        PADDR = 12'h004; PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
        #1;
        n_checks++;
        if (PRDATA !== 32'h0) begin
            n_errors++;
            $display("FAIL setup_phase_prdata: got %h, required 0", PRDATA);
        end
        PSEL = 1'b0;
        timer_irq_i = 2'b01;
        step();
        timer_irq_i = 2'b00;
        apb_read(2'd0, d);
        n_checks++;
        if (d !== 32'h1 || irq_req_o !== 1'b0) begin
            n_errors++;
            $display("FAIL single_n1: pending=%h req=%b, required 1 0", d, irq_req_o);
        end
        step();
        n_checks++;
        if (irq_req_o !== 1'b1 || irq_id_o !== 1'b0) begin
            n_errors++;
            $display("FAIL single_n2: req=%b id=%b, required 1 0", irq_req_o, irq_id_o);
        end
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        apb_read(2'd0, d);
        n_checks++;
        if (d !== 32'h0 || irq_req_o !== 1'b0) begin
            n_errors++;
            $display("FAIL single_ack: pending=%h req=%b, required 0 0", d, irq_req_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        timer_irq_i = 2'b11;
        step();
        timer_irq_i = 2'b00;
        step();
        n_checks++;
        if (irq_req_o !== 1'b1 || irq_id_o !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_first: req=%b id=%b, required 1 1", irq_req_o, irq_id_o);
        end
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        n_checks++;
        if (irq_req_o !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_gap: req=%b, required 0", irq_req_o);
        end
        step();
        n_checks++;
        if (irq_req_o !== 1'b1 || irq_id_o !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_second: req=%b id=%b, required 1 0", irq_req_o, irq_id_o);
        end
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        apb_read(2'd0, d);
        n_checks++;
        if (d !== 32'h0 || irq_req_o !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_done: pending=%h req=%b, required 0 0", d, irq_req_o);
        end
    endtask

    task automatic test_hold();
        logic [31:0] d;
        timer_irq_i = 2'b10;
        step();
        timer_irq_i = 2'b00;
        step();
        apb_write(2'd1, 32'h0);
        apb_write(2'd0, 32'h2);
        n_checks++;
        if (irq_req_o !== 1'b1 || irq_id_o !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_req: req=%b id=%b, required 1 1", irq_req_o, irq_id_o);
        end
        apb_read(2'd3, d);
        n_checks++;
        if (d !== 32'h3) begin
            n_errors++;
            $display("FAIL hold_status: got %h, required 3", d);
        end
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        apb_read(2'd3, d);
        n_checks++;
        if (irq_req_o !== 1'b0 || d[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_ack: req=%b busy=%b, required 0 0", irq_req_o, d[0]);
        end
        // acknowledge while idle is ignored
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        step();
        apb_read(2'd0, d);
        n_checks++;
        if (irq_req_o !== 1'b0 || d !== 32'h0) begin
            n_errors++;
            $display("FAIL idle_ack: req=%b pending=%h, required 0 0", irq_req_o, d);
        end
    endtask

    task automatic test_miss();
        logic [31:0] d;
        logic [31:0] want;
        apb_write(2'd2, 32'h0);
        for (int i = 0; i < 3; i++) begin
            timer_irq_i = 2'b01;
            step();
            timer_irq_i = 2'b00;
            step();
        end
        apb_read(2'd0, d);
        n_checks++;
        if (d !== 32'h1 || irq_req_o !== 1'b0) begin
            n_errors++;
            $display("FAIL miss_pending: pending=%h req=%b, required 1 0", d, irq_req_o);
        end
`ifdef TIMER_IRQ_MISS_CNT_EN
        want = 32'h0000_0002;
`else
        want = 32'h0000_0000;
`endif
        apb_read(2'd2, d);
        n_checks++;
        if (d !== want) begin
            n_errors++;
            $display("FAIL miss_count: got %h, required %h", d, want);
        end
        apb_write(2'd2, 32'hFFFF_FFFF);
        apb_read(2'd2, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_errors++;
            $display("FAIL miss_clear: got %h, required 0", d);
        end
        timer_irq_i = 2'b10;
        for (int i = 0; i < 300; i++) step();
        timer_irq_i = 2'b00;
        step();
`ifdef TIMER_IRQ_MISS_CNT_EN
        want = 32'h0000_FF00;
`else
        want = 32'h0000_0000;
`endif
        apb_read(2'd2, d);
        n_checks++;
        if (d !== want) begin
            n_errors++;
            $display("FAIL miss_saturate: got %h, required %h", d, want);
        end
        apb_write(2'd0, 32'h3);
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] want;
        logic [31:0] cmp_mask;
        logic [1:0]  idx;
        int          op;
        apb_write(2'd1, 32'h3);
        for (int c = 0; c < 800; c++) begin
            timer_irq_i = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            irq_ack_i   = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            op = $urandom_range(0, 5);
            if (op == 0) begin
                PADDR   = 12'($urandom);
                PWDATA  = $urandom;
                PWRITE  = 1'b1;
                PSEL    = 1'b1;
                PENABLE = 1'b1;
            end else if (op == 1) begin
                idx = 2'($urandom);
                apb_read(idx, d);
                want     = exp_reg(idx);
                // latched ID in STATUS is only defined while busy
                cmp_mask = (idx == 2'd3 && !m_busy) ? 32'hFFFF_FFFD : 32'hFFFF_FFFF;
                n_checks++;
                if ((d & cmp_mask) !== (want & cmp_mask)) begin
                    n_errors++;
                    $display("FAIL rand_read c=%0d reg%0d: got %h, required %h", c, idx, d,
                             want);
                end
            end
            step();
            PSEL    = 1'b0;
            PENABLE = 1'b0;
            PWRITE  = 1'b0;
            n_checks++;
            if (irq_req_o !== m_busy || (m_busy && irq_id_o !== m_id)) begin
                n_errors++;
                $display("FAIL rand_irq c=%0d: req=%b id=%b, required %b %b", c, irq_req_o,
                         irq_id_o, m_busy, m_id);
            end
        end
        timer_irq_i = 2'b00;
        irq_ack_i   = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        apb_write(2'd1, 32'h3);
        timer_irq_i = 2'b01;
        step();
        timer_irq_i = 2'b00;
        repeat (3) begin
            if (!m_busy) step();
        end
        n_checks++;
        if (irq_req_o !== 1'b1) begin
            n_errors++;
            $display("FAIL areset_pre: req=%b, required 1", irq_req_o);
        end
        #2;
        HRESETn = 1'b0;
        #1;
        n_checks++;
        if (irq_req_o !== 1'b0 || irq_id_o !== 1'b0) begin
            n_errors++;
            $display("FAIL areset_now: req=%b id=%b, required 0 0", irq_req_o, irq_id_o);
        end
        model_reset();
        timer_irq_i = 2'b11;
        @(posedge HCLK);
        #1;
        timer_irq_i = 2'b00;
        #2;
        HRESETn = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            apb_read(2'(i), d);
            n_checks++;
            if (d !== 32'h0) begin
                n_errors++;
                $display("FAIL areset_reg%0d: got %h, required 0", i, d);
            end
        end
        n_checks++;
        if (irq_req_o !== 1'b0) begin
            n_errors++;
            $display("FAIL areset_after: req=%b, required 0", irq_req_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_miss();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
